serial_fulladd_unit: RTL and testbench

//  Bit-serial N-bit adder: the addition counterpart of the full-subtractor datapath.
//  One full-adder cell plus a carry flip-flop processes operands LSB-first, one bit per clock.

---
 rtl/serial_fulladd_unit.sv | 109 ++++++++++
 tb/tb_serial_fulladd_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_fulladd_unit.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a carry flip-flop, LSB first, one bit per clock.
// Start/busy/done handshake; sum and cout hold the last result until the next accepted start.
module serial_fulladd_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] sr;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             c_nxt;
    logic             last_bit;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SHIFT: busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // The single full-adder cell working on the current LSBs.
    always_comb begin
        s     = ra[0] ^ rb[0] ^ c;
        c_nxt = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
    end

    // Sum bits enter at the MSB, so after WIDTH shifts bit 0 lands in sr[0].
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ra  <= '0;
            rb  <= '0;
            sr  <= '0;
            c   <= 1'b0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ra  <= a;
                        rb  <= b;
                        c   <= cin;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    ra  <= {1'b0, ra[WIDTH-1:1]};
                    rb  <= {1'b0, rb[WIDTH-1:1]};
                    sr  <= {s, sr[WIDTH-1:1]};
                    c   <= c_nxt;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sum  = sr;
    assign cout = c;

endmodule

// File: tb/tb_serial_fulladd_unit.sv
// Self-checking bench for serial_fulladd_unit (WIDTH=8): directed vectors, handshake corner
// cases, mid-operation reset and randomized ops against a plain-arithmetic reference.
module tb_serial_fulladd_unit;

    localparam int WIDTH = 8;
    localparam int BUDGET = 40;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int total;
    int bad;

    int               busy_cycles;
    int               done_count;
    logic [WIDTH-1:0] got_sum;
    logic             got_cout;
    logic             finished;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
    } vec_t;

    vec_t vecs[6];

    serial_fulladd_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drives one start at a falling edge, then follows the op until busy drops.
    // Operand inputs are scrambled after acceptance; they must not matter.
    task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tc);
        @(negedge clk);
        start = 1'b1;
        a = ta;
        b = tb;
        cin = tc;
        busy_cycles = 0;
        done_count = 0;
        finished = 1'b0;
        got_sum = '0;
        got_cout = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            start = 1'b0;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            cin = 1'($urandom);
            if (busy) busy_cycles++;
            if (done) begin
                done_count++;
                got_sum = sum;
                got_cout = cout;
            end
            if (!busy) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) checkOutput("timeout", 32'(busy_cycles), 32'(WIDTH + 1));
    endtask

    task automatic checkOp(input string name, input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
        checkOutput({name, ".sum"}, 32'(got_sum), 32'(exp_sum));
        checkOutput({name, ".cout"}, 32'(got_cout), 32'(exp_cout));
        checkOutput({name, ".done_count"}, 32'(done_count), 32'd1);
        checkOutput({name, ".busy_cycles"}, 32'(busy_cycles), 32'(WIDTH + 1));
    endtask

    initial begin
        logic [WIDTH:0]   ref_full;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        logic [WIDTH-1:0] held;
        int               seen_done;

        total = 0;
        bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;

        vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};

        repeat (3) @(negedge clk);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.sum", 32'(sum), 32'd0);
        checkOutput("reset.cout", 32'(cout), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin);
            checkOp($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_cout);
        end

        // Result must hold while idle.
        held = sum;
        repeat (4) @(negedge clk);
        checkOutput("hold.sum", 32'(sum), 32'(held));
        checkOutput("hold.cout", 32'(cout), 32'd1);

        // Start pulses in SHIFT cycle 3 and in the DONE cycle are ignored.
        @(negedge clk);
        start = 1'b1;
        a = 8'h12;
        b = 8'h34;
        cin = 1'b0;
        seen_done = 0;
        for (int k = 1; k <= WIDTH + 1; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 3 || k == WIDTH + 1) begin
                start = 1'b1;
                a = 8'hAA;
                b = 8'h55;
                cin = 1'b1;
            end
            if (done) seen_done++;
            if (k == WIDTH + 1) checkOutput("busy_ign.done_at_9", 32'(done), 32'd1);
        end
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_ign.done_count", 32'(seen_done), 32'd1);
        checkOutput("busy_ign.idle_after", 32'(busy), 32'd0);
        checkOutput("busy_ign.sum", 32'(sum), 32'h46);
        checkOutput("busy_ign.cout", 32'(cout), 32'd0);
        // A start in the cycle right after done is accepted.
        start = 1'b1;
        a = 8'h01;
        b = 8'h02;
        cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("after_done.accepted", 32'(busy), 32'd1);
        repeat (WIDTH) @(negedge clk);
        checkOutput("after_done.done", 32'(done), 32'd1);
        checkOutput("after_done.sum", 32'(sum), 32'h03);

        // Reset during SHIFT abandons the op with no done pulse.
        @(negedge clk);
        start = 1'b1;
        a = 8'hC3;
        b = 8'h7E;
        cin = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midreset.busy", 32'(busy), 32'd0);
        checkOutput("midreset.done", 32'(done), 32'd0);
        checkOutput("midreset.sum", 32'(sum), 32'd0);
        checkOutput("midreset.cout", 32'(cout), 32'd0);
        seen_done = 0;
        repeat (WIDTH + 2) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        checkOutput("midreset.no_activity", 32'(seen_done), 32'd0);
        applyStimulus(8'h80, 8'h80, 1'b0);
        checkOp("midreset.newop", 8'h00, 1'b1);

        // Randomized ops vs plain arithmetic.
        for (int n = 0; n < 1000; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            ref_full = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
            applyStimulus(ra, rb, rc);
            if (got_sum !== ref_full[WIDTH-1:0] || got_cout !== ref_full[WIDTH] ||
                done_count != 1 || busy_cycles != WIDTH + 1) begin
                checkOp($sformatf("rand%0d", n), ref_full[WIDTH-1:0], ref_full[WIDTH]);
            end else begin
                total++;
            end
            if (bad > 20) break;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
